// File: rtl/commutation_top_pkg.sv
// -----------------------------------------------------------------------------
// commutation_top_pkg
// Shared constants for the matrix-converter commutation controller:
//   - load selection codes carried on DesiredLoad fields
//   - per-phase commutation FSM state encoding
//   - bit positions of the forward/reverse device inside a switch pair
// -----------------------------------------------------------------------------
package commutation_top_pkg;

  // Load selection codes (one 2-bit field per output phase)
  localparam logic [1:0] NUL = 2'b00;
  localparam logic [1:0] LAA = 2'b01;
  localparam logic [1:0] LBB = 2'b10;
  localparam logic [1:0] LCC = 2'b11;

  // Device positions inside a bidirectional switch pair
  localparam int FWD = 1;
  localparam int REV = 0;

  // Four-step commutation states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4
  } phase_state_t;

endpackage

// File: rtl/commutation_top_if.sv
// -----------------------------------------------------------------------------
// commutation_top_if
// Bundles the controller's operational signals.
//   start        enable, 0 forces all switches off
//   shorts[2:0]  short-fault flags {A,B,C}
//   DesiredLoad  requested input per load {A[5:4],B[3:2],C[1:0]}
//   CurrentSign  current polarity per phase {A,B,C}, 1 = positive
//   Sout[17:0]   gate drives, load A in [17:12], B in [11:6], C in [5:0]
//   shorted      latched fault indicator
// master = the side that drives requests, slave = the controller.
// -----------------------------------------------------------------------------
interface commutation_top_if;
  logic        start;
  logic [2:0]  shorts;
  logic [5:0]  DesiredLoad;
  logic [2:0]  CurrentSign;
  logic [17:0] Sout;
  logic        shorted;

  modport master (
    output start, shorts, DesiredLoad,
    input  CurrentSign, Sout, shorted
  );

  modport slave (
    input  start, shorts, DesiredLoad,
    output CurrentSign, Sout, shorted
  );
endinterface

// File: rtl/commutation_top_phase_commutator.sv
// -----------------------------------------------------------------------------
// phase_commutator
// Four-step current-sign commutation for one load phase.
//   clk, rst     clock, synchronous active-low reset
//   enable       0 forces IDLE with no input selected
//   desired[1:0] requested input (NUL/LAA/LBB/LCC)
//   sign         present current polarity of this phase
//   gates[5:0]   switch pairs, input A in [5:4], B in [3:2], C in [1:0]
// -----------------------------------------------------------------------------
module phase_commutator
  import commutation_top_pkg::*;
#(
  parameter int STEP_CYCLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] desired,
  input  logic       sign,
  output logic [5:0] gates
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);

  phase_state_t   state, stateNext;
  logic [1:0]     cur, curNext;
  logic [1:0]     tgt, tgtNext;
  logic           sgn, sgnNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [1:0]     condPair;

  // Places a pair value at the position of the given input; NUL places
  // nothing, which is what makes NUL endpoints consume time silently.
  function automatic logic [5:0] placePair(logic [1:0] code, logic [1:0] pair);
    logic [5:0] m;
    m = '0;
    case (code)
      LAA:     m[5:4] = pair;
      LBB:     m[3:2] = pair;
      LCC:     m[1:0] = pair;
      default: m = '0;
    endcase
    return m;
  endfunction

  // Holds the commutation state, the endpoints of the transfer in flight,
  // the latched current sign and the dwell counter of the present step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cur   <= NUL;
      tgt   <= NUL;
      sgn   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cur   <= curNext;
      tgt   <= tgtNext;
      sgn   <= sgnNext;
      cnt   <= cntNext;
    end
  end

  // Next-state and gate pattern. The sign is captured once when a transfer
  // starts, so a polarity flip mid-sequence cannot reorder the steps.
  always_comb begin
    stateNext = state;
    curNext   = cur;
    tgtNext   = tgt;
    sgnNext   = sgn;
    cntNext   = cnt;
    gates     = '0;
    condPair  = '0;
    if (sgn) condPair[FWD] = 1'b1;
    else     condPair[REV] = 1'b1;

    if (!enable) begin
      stateNext = IDLE;
      curNext   = NUL;
      cntNext   = '0;
    end else if (state == IDLE) begin
      if (desired != cur) begin
        stateNext = S1;
        tgtNext   = desired;
        sgnNext   = sign;
        cntNext   = '0;
      end
    end else if (cnt == LAST_CNT) begin
      cntNext = '0;
      case (state)
        S1:      stateNext = S2;
        S2:      stateNext = S3;
        S3:      stateNext = S4;
        default: begin
          stateNext = IDLE;
          curNext   = tgt;
        end
      endcase
    end else begin
      cntNext = cnt + CNT_W'(1);
    end

    // Only S2 has two pairs on at once, and both carry just the device
    // that conducts the present current direction.
    case (state)
      IDLE:    gates = placePair(cur, 2'b11);
      S1:      gates = placePair(cur, condPair);
      S2:      gates = placePair(cur, condPair) | placePair(tgt, condPair);
      S3:      gates = placePair(tgt, condPair);
      S4:      gates = placePair(tgt, 2'b11);
      default: gates = '0;
    endcase
  end

endmodule

// File: rtl/commutation_top.sv
// -----------------------------------------------------------------------------
// commutation_top
// Three-phase matrix-converter switch controller.
//   clk   system clock
//   rst   synchronous active-low reset
//   bus   commutation_top_if.slave: start, shorts, DesiredLoad in;
//         CurrentSign, Sout, shorted out
// Holds the 120-degree-offset current-sign generator, the sticky short
// fault latch and three phase_commutator instances.
// -----------------------------------------------------------------------------
module commutation_top
  import commutation_top_pkg::*;
#(
  parameter int HALF_PERIOD = 416667,
  parameter int OFFSET_B    = 277778,
  parameter int OFFSET_C    = 138889,
  parameter int STEP_CYCLES = 50
) (
  input logic             clk,
  input logic             rst,
  commutation_top_if.slave bus
);

  logic [31:0]      signTimer [3];
  logic [2:0]       signReg;
  logic             shortedReg;
  logic             enable;
  logic [2:0][5:0]  phaseGates;

  // Free-running sign generator; timer index 0 is phase A (sign bit 2).
  // Reloading to 1 rather than 0 folds this cycle's increment in, so each
  // toggle is exactly HALF_PERIOD cycles apart.
  always_ff @(posedge clk) begin
    if (!rst) begin
      signTimer[0] <= 32'd0;
      signTimer[1] <= 32'(OFFSET_B);
      signTimer[2] <= 32'(OFFSET_C);
      signReg      <= 3'b110;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (signTimer[i] >= 32'(HALF_PERIOD)) begin
          signTimer[i]  <= 32'd1;
          signReg[2-i]  <= ~signReg[2-i];
        end else begin
          signTimer[i]  <= signTimer[i] + 32'd1;
        end
      end
    end
  end

  // Sticky fault latch: only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst) shortedReg <= 1'b0;
    else if (bus.shorts != 3'b000) shortedReg <= 1'b1;
  end

  // A fault flag kills the phases on the very edge it is seen, not one later.
  assign enable = bus.start && !shortedReg && (bus.shorts == 3'b000);

  for (genvar g = 0; g < 3; g++) begin : gPhase
    phase_commutator #(.STEP_CYCLES(STEP_CYCLES)) uPhase (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .desired (bus.DesiredLoad[2*g+1 -: 2]),
      .sign    (signReg[g]),
      .gates   (phaseGates[g])
    );
  end

  assign bus.Sout        = phaseGates;
  assign bus.CurrentSign = signReg;
  assign bus.shorted     = shortedReg;

endmodule

// File: tb/tb_commutation_top.sv
// -----------------------------------------------------------------------------
// tb_commutation_top
// Self-checking bench for commutation_top with a timeline-based model of
// the sign generator and the four-step commutation sequence.
// -----------------------------------------------------------------------------
module tb_commutation_top;

  localparam int HALF = 12;
  localparam int OFFB = 8;
  localparam int OFFC = 4;
  localparam int STEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  commutation_top_if bus();

  commutation_top #(
    .HALF_PERIOD (HALF),
    .OFFSET_B    (OFFB),
    .OFFSET_C    (OFFC),
    .STEP_CYCLES (STEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edgeNum  = 0;
  bit modelReady = 1'b0;

  bit         mBusy  [3];
  int         mStart [3];
  logic [1:0] mCur   [3];
  logic [1:0] mTgt   [3];
  logic       mSgn   [3];
  logic       mShorted;

  logic [17:0] expSout;
  logic [2:0]  expSign;
  logic        expShorted;

  // Sign of phase p after edge n: count how many toggle instants have passed.
  function automatic logic signAt(int p, int n);
    int   offs, first, toggles;
    logic init;
    offs    = (p == 0) ? 0 : ((p == 1) ? OFFB : OFFC);
    init    = (p == 2) ? 1'b0 : 1'b1;
    first   = HALF - offs + 1;
    toggles = (n < first) ? 0 : ((n - first) / HALF + 1);
    return init ^ toggles[0];
  endfunction

  // Expected 6-bit field of load p after edge n, built from the step number
  // the transfer has reached: the outgoing pair sheds its idle device at
  // step 1 and its working device at step 3; the incoming pair gains the
  // working device at step 2 and the idle one at step 4.
  function automatic logic [5:0] expectedField(int p, int n);
    logic [1:0] pairs [4];
    logic [1:0] cond, idleDev;
    int         m;
    for (int i = 0; i < 4; i++) pairs[i] = 2'b00;
    if (!mBusy[p]) begin
      if (mCur[p] != 2'b00) pairs[mCur[p]] = 2'b11;
    end else begin
      m       = (n - mStart[p]) / STEP + 1;
      cond    = mSgn[p] ? 2'b10 : 2'b01;
      idleDev = ~cond;
      if (mCur[p] != 2'b00) begin
        pairs[mCur[p]] = 2'b11;
        if (m >= 1) pairs[mCur[p]] = pairs[mCur[p]] & ~idleDev;
        if (m >= 3) pairs[mCur[p]] = pairs[mCur[p]] & ~cond;
      end
      if (mTgt[p] != 2'b00) begin
        pairs[mTgt[p]] = 2'b00;
        if (m >= 2) pairs[mTgt[p]] = pairs[mTgt[p]] | cond;
        if (m >= 4) pairs[mTgt[p]] = pairs[mTgt[p]] | idleDev;
      end
    end
    return {pairs[1], pairs[2], pairs[3]};
  endfunction

  task automatic checkOutput(input string name, input logic [17:0] actual,
                             input logic [17:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b at edge %0d", name, actual, expected, edgeNum);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] sh, input logic [5:0] dl);
    bus.start       = st;
    bus.shorts      = sh;
    bus.DesiredLoad = dl;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic waitUntilEdge(input int k);
    while (edgeNum < k) @(negedge clk);
  endtask

  task automatic checkFieldA(input string name, input int k, input logic [5:0] expected);
    waitUntilEdge(k);
    checkOutput(name, 18'(bus.Sout[17:12]), 18'(expected));
  endtask

  // Reference model advanced on every clock edge from the bench's own inputs.
  always @(posedge clk) begin : modelUpdate
    logic       en;
    logic [1:0] want;
    if (!rst) begin
      edgeNum  = 0;
      mShorted = 1'b0;
      for (int p = 0; p < 3; p++) begin
        mBusy[p]  = 1'b0;
        mStart[p] = 0;
        mCur[p]   = 2'b00;
        mTgt[p]   = 2'b00;
        mSgn[p]   = 1'b0;
      end
      modelReady = 1'b1;
    end else begin
      edgeNum = edgeNum + 1;
      en = bus.start && !mShorted && (bus.shorts == 3'b000);
      if (bus.shorts != 3'b000) mShorted = 1'b1;
      for (int p = 0; p < 3; p++) begin
        want = bus.DesiredLoad[5-2*p -: 2];
        if (!en) begin
          mBusy[p] = 1'b0;
          mCur[p]  = 2'b00;
        end else if (mBusy[p]) begin
          if (edgeNum - mStart[p] >= 4 * STEP) begin
            mBusy[p] = 1'b0;
            mCur[p]  = mTgt[p];
          end
        end else if (want != mCur[p]) begin
          mBusy[p]  = 1'b1;
          mStart[p] = edgeNum;
          mTgt[p]   = want;
          mSgn[p]   = signAt(p, edgeNum - 1);
        end
      end
    end
    expSign    = {signAt(0, edgeNum), signAt(1, edgeNum), signAt(2, edgeNum)};
    for (int p = 0; p < 3; p++) expSout[17-6*p -: 6] = expectedField(p, edgeNum);
    expShorted = mShorted;
  end

  // Every-cycle comparison against the model, plus a shoot-through guard:
  // two pairs of one load may only both be on if each holds the same
  // single device.
  always @(negedge clk) begin : compare
    logic       ok;
    logic [1:0] firstPair, pr;
    int         nz;
    if (modelReady) begin
      checkOutput("Sout", bus.Sout, expSout);
      checkOutput("CurrentSign", 18'(bus.CurrentSign), 18'(expSign));
      checkOutput("shorted", 18'(bus.shorted), 18'(expShorted));
      ok = 1'b1;
      for (int l = 0; l < 3; l++) begin
        nz = 0;
        firstPair = 2'b00;
        for (int i = 0; i < 3; i++) begin
          pr = bus.Sout[6*l + 2*i +: 2];
          if (pr != 2'b00) begin
            nz++;
            if (nz == 1) firstPair = pr;
            else if (pr != firstPair || pr == 2'b11) ok = 1'b0;
          end
        end
        if (nz > 2) ok = 1'b0;
      end
      checkOutput("no_shoot_through", 18'(ok), 18'd1);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed literals, then random traffic.
  initial begin : stimulus
    int r;
    applyStimulus(1'b1, 3'b000, 6'b000000);
    applyReset();
    checkOutput("reset_Sout", bus.Sout, 18'd0);
    checkOutput("reset_CurrentSign", 18'(bus.CurrentSign), 18'(3'b110));
    checkOutput("reset_shorted", 18'(bus.shorted), 18'd0);

    applyStimulus(1'b1, 3'b000, 6'b010000);
    checkFieldA("nul_to_a_step1", 1, 6'b000000);
    checkFieldA("nul_to_a_step2", 5, 6'b100000);
    checkOutput("sign_edge5", 18'(bus.CurrentSign), 18'(3'b100));
    waitUntilEdge(9);
    checkOutput("sign_edge9", 18'(bus.CurrentSign), 18'(3'b101));
    checkFieldA("nul_to_a_step4", 13, 6'b110000);
    checkOutput("sign_edge13", 18'(bus.CurrentSign), 18'(3'b001));

    checkFieldA("a_idle", 25, 6'b110000);
    applyStimulus(1'b1, 3'b000, 6'b100000);
    checkFieldA("a_to_b_pos_s1", 26, 6'b100000);
    checkFieldA("a_to_b_pos_s2", 30, 6'b101000);
    checkFieldA("a_to_b_pos_s3", 34, 6'b001000);
    checkFieldA("a_to_b_pos_s4", 38, 6'b001100);

    waitUntilEdge(42);
    applyStimulus(1'b1, 3'b000, 6'b010000);
    checkFieldA("b_to_a_neg_s1", 43, 6'b000100);
    checkFieldA("b_to_a_neg_s2", 47, 6'b010100);
    checkFieldA("b_to_a_neg_s3", 51, 6'b010000);
    checkFieldA("b_to_a_neg_s4", 55, 6'b110000);

    waitUntilEdge(59);
    applyStimulus(1'b1, 3'b000, 6'b110000);
    waitUntilEdge(62);
    applyStimulus(1'b1, 3'b001, 6'b110000);
    waitUntilEdge(63);
    applyStimulus(1'b1, 3'b000, 6'b011011);
    checkOutput("fault_Sout", bus.Sout, 18'd0);
    checkOutput("fault_shorted", 18'(bus.shorted), 18'd1);
    waitUntilEdge(70);
    checkOutput("fault_sticky_Sout", bus.Sout, 18'd0);
    checkOutput("fault_sticky", 18'(bus.shorted), 18'd1);

    applyStimulus(1'b1, 3'b000, 6'b010000);
    applyReset();
    checkOutput("fault_cleared", 18'(bus.shorted), 18'd0);
    checkFieldA("recovered_s2", 5, 6'b100000);
    waitUntilEdge(6);
    applyStimulus(1'b0, 3'b000, 6'b010000);
    waitUntilEdge(7);
    checkOutput("start_low_Sout", bus.Sout, 18'd0);
    waitUntilEdge(8);
    applyStimulus(1'b1, 3'b000, 6'b111111);
    waitUntilEdge(13);
    checkOutput("all_to_c_s2", bus.Sout, 18'b000010_000001_000001);
    waitUntilEdge(21);
    checkOutput("all_to_c_s4", bus.Sout, 18'b000011_000011_000011);
    waitUntilEdge(25);
    checkOutput("all_to_c_idle", bus.Sout, 18'b000011_000011_000011);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 999);
      bus.shorts = (r < 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      rst = (r >= 2 && r < 5) ? 1'b0 : 1'b1;
      if (r >= 5 && r < 18) bus.start = ~bus.start;
      if ($urandom_range(0, 7) == 0) bus.DesiredLoad = 6'($urandom);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.shorts = 3'b000;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
